// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the register file write port from the LSU and ALU, with pending-write lookup.
// Define WB_BYPASS_EN to build the fwd1/fwd2 data select; without it fwd1/fwd2 are tied to 0.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [AW-1:0]          lsu_addr,
    input  logic [DW-1:0]          lsu_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_addr,
    input  logic [DW-1:0]          alu_data,
    output logic                   WE3,
    output logic [AW-1:0]          A3,
    output logic [DW-1:0]          WD3,
    input  logic [AW-1:0]          A1,
    input  logic [AW-1:0]          A2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [DW-1:0]          fwd1,
    output logic [DW-1:0]          fwd2,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] alu_slot;
    logic          lsu_fire;
    logic          alu_fire;
    logic          pop;

    // Handshake: a producer transfers on a rising edge when valid && ready; it holds
    // addr/data while valid is high and ready is low. Readies use only the registered
    // count, so a same-cycle pop never raises them.
    assign lsu_ready = rst & (count < FULL);
    assign alu_ready = rst & ((count < ALMOST) | ((count < FULL) & ~lsu_valid));

    assign lsu_fire = lsu_valid & lsu_ready;
    assign alu_fire = alu_valid & alu_ready;
    assign pop      = (count != '0);
    assign alu_slot = wr_ptr + PW'(lsu_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(lsu_fire) + PW'(alu_fire);
            count  <= count + CW'(lsu_fire) + CW'(alu_fire) - CW'(pop);
        end
    end

    // Entry storage is deliberately not reset; occupancy is defined by rd_ptr/count only.
    always_ff @(posedge clk) begin
        if (lsu_fire) begin
            q_addr[wr_ptr] <= lsu_addr;
            q_data[wr_ptr] <= lsu_data;
        end
        if (alu_fire) begin
            q_addr[alu_slot] <= alu_addr;
            q_data[alu_slot] <= alu_data;
        end
    end

    assign WE3 = pop;
    assign A3  = pop ? q_addr[rd_ptr] : '0;
    assign WD3 = pop ? q_data[rd_ptr] : '0;

`ifdef WB_BYPASS_EN
    logic [PW-1:0] sel1;
    logic [PW-1:0] sel2;
`endif
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match found is the youngest pending write.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
`ifdef WB_BYPASS_EN
        sel1 = '0;
        sel2 = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (q_addr[idx] == A1) begin
                    hit1 = 1'b1;
`ifdef WB_BYPASS_EN
                    sel1 = idx;
`endif
                end
                if (q_addr[idx] == A2) begin
                    hit2 = 1'b1;
`ifdef WB_BYPASS_EN
                    sel2 = idx;
`endif
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1 = hit1 ? q_data[sel1] : '0;
    assign fwd2 = hit2 ? q_data[sel2] : '0;
`else
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writeback-side initiator for the 32x32 register file.
- Accepts completed results from two producers, the ALU and the load/store unit (LSU), over valid/ready handshakes.
- Buffers results in a small in-order queue and drives the register file write port (WE3/A3/WD3) at most one write per cycle.
- Exposes a pending-write lookup for the two decode read addresses, so decode can stall or forward values not yet written.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- lsu_valid  input  1  LSU result valid.
- lsu_ready  output  1  queue accepts LSU result this cycle.
- lsu_addr  input  AW  LSU destination register.
- lsu_data  input  DW  LSU result.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  queue accepts ALU result this cycle.
- alu_addr  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- WE3  output  1  register file write enable.
- A3  output  AW  register file write address.
- WD3  output  DW  register file write data.
- A1  input  AW  decode read address 1 (lookup).
- A2  input  AW  decode read address 2 (lookup).
- hit1  output  1  queued write pending to A1.
- hit2  output  1  queued write pending to A2.
- fwd1  output  DW  youngest pending data for A1.
- fwd2  output  DW  youngest pending data for A2.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset:
  - rst low asynchronously clears read/write pointers and count to 0.
  - Entry storage is not cleared.
  - While rst is low, WE3, A3, WD3, hit1/2, fwd1/2, lsu_ready and alu_ready are all 0.
  - Reset asserted mid-operation discards all queued writes; no partial write is issued.
- Handshake:
  - A transfer occurs on a rising edge when valid and ready are both 1.
  - Producers hold addr/data stable while valid is high and ready is low.
- Ready rules (combinational, from registered count c):
  - lsu_ready = (c < DEPTH).
  - alu_ready = (c < DEPTH-1) OR (c < DEPTH AND NOT lsu_valid).
  - Same-cycle pop does not raise ready; this is conservative by design.
- Push order:
  - When both producers transfer in the same cycle, the LSU entry is written first (older) and the ALU entry second.
  - Pointers advance by the number of transfers (0, 1 or 2).
- Drain:
  - Whenever c > 0: WE3 = 1 and A3/WD3 = head entry. The head pops on that edge.
  - Write latency: an entry pushed into an empty queue appears on WE3 the following cycle.
  - When c == 0: WE3 = 0, A3 = 0, WD3 = 0.
- Count update:
  - count_next = count + pushes − (c > 0 ? 1 : 0).
  - count never exceeds DEPTH; pointers wrap modulo DEPTH.
- Full and empty:
  - When full (c == DEPTH), both readies are 0.
  - At c == DEPTH-1 with both valid, only the LSU is accepted.
- Lookup:
  - hitN = 1 if any occupied entry has addr == AN.
  - fwdN = data of the youngest matching entry.
  - The head entry being written this cycle still counts as pending.
  - Incoming (not yet accepted) producer data is not searched.
- Register 0 is treated as an ordinary register.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: fwd1/fwd2 carry the youngest matching data as described above.
- Undefined:
  - fwd1/fwd2 are tied to 0 and no data-select logic is built.
  - hit1/hit2 still operate, and decode must stall on a hit.

Test Plan:
- Reset, then lsu_valid=1, lsu_addr=9, lsu_data=0x20 for 1 cycle -> next cycle WE3=1, A3=9, WD3=0x20; the cycle after, WE3=0 and count=0.
- Same cycle: LSU (3, 0xAAAA) and ALU (3, 0xBBBB) with queue empty -> writes issued as A3=3/0xAAAA then A3=3/0xBBBB on consecutive cycles.
- Hold both producers valid with DEPTH=4 and the drain running -> count never exceeds 4; at c=3 only lsu_ready=1; all writes appear on A3/WD3 in acceptance order.
- Queue holds (5, 0x11) and a younger (5, 0x22); A1=5, A2=6 -> hit1=1, fwd1=0x22 (0 without WB_BYPASS_EN), hit2=0.
- Three entries queued, rst pulsed low mid-cycle -> WE3, count and readies drop to 0 immediately; after release no stale write appears.
- Queue full (4 entries) with alu_valid held high -> alu_ready stays 0 until count drops to 2 (or to 3 with lsu_valid=0); ALU data is accepted unchanged.
